// File: rtl/alu_unit_if.sv
// Shared ALU types plus the issue-side and writeback-side handshake interfaces
// used by alu_unit.
package taiga_config;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    LOGIC_ADD = 2'b00,
    LOGIC_XOR = 2'b01,
    LOGIC_OR  = 2'b10,
    LOGIC_AND = 2'b11
  } logic_op_t;

  typedef enum logic [1:0] {
    ALU_ADD_SUB   = 2'b00,
    ALU_SLT       = 2'b01,
    ALU_SHIFT     = 2'b10,
    ALU_SHIFT_ALT = 2'b11
  } alu_op_t;

  // Bit XLEN of in1/in2 is the sign pad chosen by the decoder
  // (sign bit for signed compares, zero otherwise).
  typedef struct packed {
    logic [XLEN:0]   in1;
    logic [XLEN:0]   in2;
    logic            subtract;
    logic            arith;
    logic            lshift;
    logic [XLEN-1:0] shifter_in;
    logic_op_t       logic_op;
    alu_op_t         op;
  } alu_inputs_t;
endpackage

interface alu_ex_if;
  logic new_request_dec;
  logic ready;

  modport master (output new_request_dec, input ready);
  modport slave  (input new_request_dec, output ready);
endinterface

interface alu_wb_if;
  import taiga_config::*;
  logic            done_next_cycle;
  logic            accepted;
  logic [XLEN-1:0] rd;

  modport master (output done_next_cycle, output rd, input accepted);
  modport slave  (input done_next_cycle, input rd, output accepted);
endinterface

// File: rtl/alu_unit.sv
// RV32I single-cycle ALU with buffered writeback result.
// ALU_RESULT_BUFFER_EN selects a 2-entry result FIFO instead of a single register.
module alu_unit
  import taiga_config::*;
(
  input  logic        clk,
  input  logic        rst,
  input  alu_inputs_t alu_inputs,
  alu_ex_if.slave     alu_ex,
  alu_wb_if.master    alu_wb
);

  logic [XLEN:0]          sum;
  logic signed [XLEN:0]   shift_ext;
  logic [XLEN-1:0]        shift_raw;
  logic [XLEN-1:0]        shift_rev;
  logic [XLEN-1:0]        result;

  always_comb begin
    sum = alu_inputs.subtract ? (alu_inputs.in1 - alu_inputs.in2)
                              : (alu_inputs.in1 + alu_inputs.in2);

    // Left shifts arrive bit-reversed, so one right shifter serves both directions.
    shift_ext = $signed({alu_inputs.arith, alu_inputs.shifter_in}) >>> alu_inputs.in2[4:0];
    shift_raw = shift_ext[XLEN-1:0];
    shift_rev = '0;
    for (int unsigned i = 0; i < XLEN; i++)
      shift_rev[i] = shift_raw[XLEN-1-i];

    result = '0;
    unique case (alu_inputs.op)
      ALU_ADD_SUB: begin
        unique case (alu_inputs.logic_op)
          LOGIC_ADD: result = sum[XLEN-1:0];
          LOGIC_XOR: result = alu_inputs.in1[XLEN-1:0] ^ alu_inputs.in2[XLEN-1:0];
          LOGIC_OR:  result = alu_inputs.in1[XLEN-1:0] | alu_inputs.in2[XLEN-1:0];
          LOGIC_AND: result = alu_inputs.in1[XLEN-1:0] & alu_inputs.in2[XLEN-1:0];
        endcase
      end
      ALU_SLT: result = {{(XLEN-1){1'b0}}, sum[XLEN]};
      default: result = alu_inputs.lshift ? shift_rev : shift_raw;
    endcase
  end

  logic            push;
  logic            pop;
  logic            head_valid;
  logic [XLEN-1:0] head;

  assign push = alu_ex.new_request_dec;
  assign pop  = alu_wb.accepted & head_valid;

`ifdef ALU_RESULT_BUFFER_EN
  logic            tail_valid;
  logic [XLEN-1:0] tail;

  // head is always the oldest entry and is never cleared on pop, so rd keeps
  // its last value once the buffer drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head       <= '0;
      tail       <= '0;
    end else if (pop) begin
      if (tail_valid) begin
        head <= tail;
        if (push)
          tail <= result;
        else
          tail_valid <= 1'b0;
      end else if (push) begin
        head <= result;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (push) begin
      if (!head_valid) begin
        head       <= result;
        head_valid <= 1'b1;
      end else begin
        tail       <= result;
        tail_valid <= 1'b1;
      end
    end
  end

  assign alu_ex.ready = ~tail_valid | alu_wb.accepted;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head       <= '0;
    end else if (push) begin
      head       <= result;
      head_valid <= 1'b1;
    end else if (pop) begin
      head_valid <= 1'b0;
    end
  end

  assign alu_ex.ready = ~head_valid | alu_wb.accepted;
`endif

  assign alu_wb.done_next_cycle = head_valid & ~alu_wb.accepted;
  assign alu_wb.rd              = head;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, handshake corner
// sequences and a randomized issue/accept run checked through a scoreboard.
module tb_alu_unit;
  import taiga_config::*;

`ifdef ALU_RESULT_BUFFER_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int MAX_CYCLES = 40000;

  typedef enum int {K_ADD, K_SUB, K_XOR, K_OR, K_AND, K_SLT, K_SLTU, K_SLL, K_SRL, K_SRA} kind_e;

  typedef struct {
    kind_e       k;
    alu_inputs_t in;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  alu_inputs_t bundle;
  alu_ex_if    ex();
  alu_wb_if    wb();

  alu_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_inputs (bundle),
    .alu_ex     (ex.slave),
    .alu_wb     (wb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // What the instruction decoder would hand the unit for each RV32I operation.
  function automatic alu_inputs_t decode(input kind_e k, input logic [31:0] a, input logic [31:0] b);
    alu_inputs_t d;
    d = '0;
    d.in1 = {1'b0, a};
    d.in2 = {1'b0, b};
    d.shifter_in = a;
    d.logic_op = LOGIC_ADD;
    d.op = ALU_ADD_SUB;
    case (k)
      K_ADD:  ;
      K_SUB:  d.subtract = 1'b1;
      K_XOR:  d.logic_op = LOGIC_XOR;
      K_OR:   d.logic_op = LOGIC_OR;
      K_AND:  d.logic_op = LOGIC_AND;
      K_SLT:  begin d.in1 = {a[31], a}; d.in2 = {b[31], b}; d.subtract = 1'b1; d.op = ALU_SLT; end
      K_SLTU: begin d.subtract = 1'b1; d.op = ALU_SLT; end
      K_SLL:  begin d.lshift = 1'b1; d.shifter_in = rev32(a); d.op = ALU_SHIFT; end
      K_SRL:  d.op = ALU_SHIFT;
      K_SRA:  begin d.arith = a[31]; d.op = ALU_SHIFT_ALT; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] model(input kind_e k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      K_ADD:  return a + b;
      K_SUB:  return a - b;
      K_XOR:  return a ^ b;
      K_OR:   return a | b;
      K_AND:  return a & b;
      K_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU: return (a < b) ? 32'd1 : 32'd0;
      K_SLL:  return a << b[4:0];
      K_SRL:  return a >> b[4:0];
      K_SRA:  return $signed(a) >>> b[4:0];
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    kind_e       k;
    logic [31:0] a, b;
    logic        acc;
    int          issued, cycles, wait_cnt;

    rst = 1'b1;
    bundle = '0;
    ex.new_request_dec = 1'b0;
    wb.accepted = 1'b0;

    vecs[0]  = '{K_ADD,  decode(K_ADD,  32'd3, 32'd7), 32'h0000000A};
    vecs[1]  = '{K_SUB,  decode(K_SUB,  32'd3, 32'd7), 32'hFFFFFFFC};
    vecs[2]  = '{K_SUB,  decode(K_SUB,  32'd1, 32'd1), 32'h00000000};
    vecs[3]  = '{K_AND,  decode(K_AND,  32'hFF00FF00, 32'h0F0F0F0F), 32'h0F000F00};
    vecs[4]  = '{K_OR,   decode(K_OR,   32'hFF00FF00, 32'h0F0F0F0F), 32'hFF0FFF0F};
    vecs[5]  = '{K_XOR,  decode(K_XOR,  32'hFF00FF00, 32'h0F0F0F0F), 32'hF00FF00F};
    vecs[6]  = '{K_SLTU, decode(K_SLTU, 32'd3, 32'd7), 32'd1};
    vecs[7]  = '{K_SLTU, decode(K_SLTU, 32'd1, 32'd1), 32'd0};
    vecs[8]  = '{K_SLTU, decode(K_SLTU, 32'd3, 32'd7), 32'd0};
    vecs[8].in.subtract = 1'b0;
    vecs[9]  = '{K_SLL,  decode(K_SLL,  32'h21212121, 32'd7),  32'h90909080};
    vecs[10] = '{K_SRL,  decode(K_SRL,  32'h81818181, 32'd14), 32'h00020606};
    vecs[11] = '{K_SRA,  decode(K_SRA,  32'h81818181, 32'd7),  32'hFF030303};
    vecs[12] = '{K_SRA,  decode(K_SRA,  32'h80000000, 32'd31), 32'hFFFFFFFF};
    vecs[13] = '{K_SLT,  decode(K_SLT,  32'hFFFFFFFF, 32'd1),  32'd1};
    vecs[14] = '{K_SLTU, decode(K_SLTU, 32'hFFFFFFFF, 32'd1),  32'd0};
    vecs[15] = '{K_SLL,  decode(K_SLL,  32'h80000001, 32'd0),  32'h80000001};

    @(posedge clk);
    tick();
    check("reset_done",  32'(wb.done_next_cycle), 32'd0);
    check("reset_rd",    wb.rd, 32'd0);
    check("reset_ready", 32'(ex.ready), 32'd1);
    rst = 1'b0;

    // Directed vectors: issue, see done, accept with done masked.
    foreach (vecs[i]) begin
      bundle = vecs[i].in;
      ex.new_request_dec = 1'b1;
      q.push_back(vecs[i].exp);
      tick();
      ex.new_request_dec = 1'b0;
      check($sformatf("vec%0d_%s_done", i, vecs[i].k.name()), 32'(wb.done_next_cycle), 32'd1);
      wb.accepted = 1'b1;
      #1;
      check($sformatf("vec%0d_%s_done_masked", i, vecs[i].k.name()), 32'(wb.done_next_cycle), 32'd0);
      check($sformatf("vec%0d_%s_rd", i, vecs[i].k.name()), wb.rd, q.pop_front());
      tick();
      wb.accepted = 1'b0;
    end

    // Accept and issue in the same cycle, then rd holds after draining.
    bundle = decode(K_ADD, 32'd5, 32'd6);
    ex.new_request_dec = 1'b1;
    q.push_back(32'd11);
    tick();
    ex.new_request_dec = 1'b0;
    wb.accepted = 1'b1;
    #1;
    check("swap_done_masked", 32'(wb.done_next_cycle), 32'd0);
    check("swap_ready", 32'(ex.ready), 32'd1);
    check("swap_rd_first", wb.rd, q.pop_front());
    bundle = decode(K_SUB, 32'd9, 32'd4);
    ex.new_request_dec = 1'b1;
    q.push_back(32'd5);
    tick();
    ex.new_request_dec = 1'b0;
    wb.accepted = 1'b0;
    #1;
    check("swap_done_second", 32'(wb.done_next_cycle), 32'd1);
    check("swap_rd_second", wb.rd, q[0]);
    wb.accepted = 1'b1;
    #1;
    check("swap_done_masked2", 32'(wb.done_next_cycle), 32'd0);
    void'(q.pop_front());
    tick();
    wb.accepted = 1'b0;
    #1;
    check("idle_done", 32'(wb.done_next_cycle), 32'd0);
    check("idle_rd_hold", wb.rd, 32'd5);

    // Reset with results pending discards them.
    bundle = decode(K_ADD, 32'd20, 32'd22);
    ex.new_request_dec = 1'b1;
    tick();
    if (CAP > 1) begin
      bundle = decode(K_OR, 32'h10, 32'h01);
      tick();
    end
    ex.new_request_dec = 1'b0;
    check("pre_reset_done", 32'(wb.done_next_cycle), 32'd1);
    check("pre_reset_ready", 32'(ex.ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_done",  32'(wb.done_next_cycle), 32'd0);
    check("mid_reset_rd",    wb.rd, 32'd0);
    check("mid_reset_ready", 32'(ex.ready), 32'd1);
    bundle = decode(K_ADD, 32'd1, 32'd1);
    ex.new_request_dec = 1'b1;
    tick();
    ex.new_request_dec = 1'b0;
    check("post_reset_done", 32'(wb.done_next_cycle), 32'd1);
    check("post_reset_rd",   wb.rd, 32'd2);
    wb.accepted = 1'b1;
    tick();
    wb.accepted = 1'b0;

    // Random issue stream with random writeback delay, scoreboard in issue order.
    issued = 0;
    cycles = 0;
    wait_cnt = int'($urandom_range(0, 15));
    while ((issued < 1000 || q.size() > 0) && cycles < MAX_CYCLES) begin
      acc = 1'b0;
      if (q.size() > 0) begin
        if (wait_cnt == 0) begin
          acc = 1'b1;
          wait_cnt = int'($urandom_range(0, 15));
        end else begin
          wait_cnt--;
        end
      end
      wb.accepted = acc;
      ex.new_request_dec = 1'b0;
      #1;
      check("rand_done", 32'(wb.done_next_cycle), 32'((q.size() > 0) && !acc));
      check("rand_ready", 32'(ex.ready), 32'((q.size() < CAP) || acc));
      if (q.size() > 0) check("rand_rd", wb.rd, q[0]);
      if (acc) void'(q.pop_front());
      if (issued < 1000 && q.size() < CAP && $urandom_range(0, 3) != 0) begin
        k = kind_e'($urandom_range(0, 9));
        a = $urandom;
        b = $urandom;
        bundle = decode(k, a, b);
        q.push_back(model(k, a, b));
        ex.new_request_dec = 1'b1;
        issued++;
      end
      tick();
      cycles++;
    end
    wb.accepted = 1'b0;
    ex.new_request_dec = 1'b0;
    check("rand_complete_issued", 32'(issued), 32'd1000);
    check("rand_complete_drained", 32'(q.size()), 32'd0);
    if (cycles >= MAX_CYCLES)
      check("rand_timeout", 32'(cycles), 32'(MAX_CYCLES - 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
